// File: rtl/img_tile_loader_if.sv
// Memory read port and local image buffer write port of the tile loader.
interface img_tile_loader_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned BUF_AW = 12
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              buf_we;
   logic [BUF_AW-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;

   modport master (
      output mem_rd_en, mem_addr, buf_we, buf_addr, buf_data,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en, mem_addr, buf_we, buf_addr, buf_data,
      output mem_rd_data
   );
endinterface

// File: rtl/img_tile_loader.sv
// Copies a C-channel N x N feature map from CNN memory into the local image
// buffer, one element per cycle, with an optional one-pixel zero border.
module img_tile_loader #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned SIZE_W  = 6,
   parameter int unsigned CH_W    = 3,
   parameter int unsigned BUF_AW  = 12,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [SIZE_W-1:0] img_size,
   input  logic [CH_W-1:0]   num_ch,
   input  logic [ADDR_W-1:0] ch_stride,
   input  logic              pad_en,
   img_tile_loader_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              overflow
);
   localparam int unsigned S_W   = SIZE_W + 1;
   localparam int unsigned K_RAW = CH_W + 2 * S_W;
   localparam int unsigned K_W   = (K_RAW > BUF_AW) ? K_RAW : BUF_AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} stateT;
   typedef struct packed {
      logic           valid;
      logic           interior;
      logic [K_W-1:0] k;
   } pipeT;

   stateT state, nextState;

   logic [SIZE_W-1:0] cfgN;
   logic [CH_W-1:0]   cfgC;
   logic [ADDR_W-1:0] cfgStride;
   logic              cfgPad;
   logic [S_W-1:0]    cfgS;

   logic [CH_W-1:0]   chIdx;
   logic [S_W-1:0]    rowIdx, colIdx;
   logic [K_W-1:0]    kIdx;
   logic [ADDR_W-1:0] chBase, rowAddr;

   pipeT pipe [MEM_LAT];
   pipeT tail;
   logic tailOver, pipeBusy, bufInterior;

   logic              inIdle, emptyMap, issuing, border, lastCol, lastRow, lastElem;
   logic [SIZE_W-1:0] effN;
   logic [CH_W-1:0]   effC, curCh;
   logic [ADDR_W-1:0] effStride, padOff, curChBase, curRowAddr, elemAddr;
   logic              effPad;
   logic [S_W-1:0]    effS, curRow, curCol;
   logic [K_W-1:0]    curK;

   logic              memRdEnNext, busyNext, doneNext;
   logic [ADDR_W-1:0] memAddrNext;

   // In IDLE the element about to issue is element 0 of the map on the inputs.
   always_comb begin
      inIdle     = (state == IDLE);
      effN       = inIdle ? img_size  : cfgN;
      effC       = inIdle ? num_ch    : cfgC;
      effStride  = inIdle ? ch_stride : cfgStride;
      effPad     = inIdle ? pad_en    : cfgPad;
      effS       = inIdle ? S_W'(img_size) + (pad_en ? S_W'(2) : S_W'(0)) : cfgS;
      padOff     = effPad ? ADDR_W'(effN) : ADDR_W'(0);
      curCh      = inIdle ? '0 : chIdx;
      curRow     = inIdle ? '0 : rowIdx;
      curCol     = inIdle ? '0 : colIdx;
      curK       = inIdle ? '0 : kIdx;
      curChBase  = inIdle ? base_addr : chBase;
      curRowAddr = inIdle ? base_addr - padOff : rowAddr;
      emptyMap   = (effN == '0) || (effC == '0);
      issuing    = inIdle ? (start && !emptyMap) : (state == ISSUE);
      lastCol    = (curCol == effS - S_W'(1));
      lastRow    = (curRow == effS - S_W'(1));
      lastElem   = lastCol && lastRow && (curCh == effC - CH_W'(1));
      border     = effPad && ((curRow == '0) || lastRow || (curCol == '0) || lastCol);
      elemAddr   = curRowAddr + ADDR_W'(curCol) - ADDR_W'(effPad);
   end

   always_comb begin
      pipeBusy = 1'b0;
      for (int j = 0; j < int'(MEM_LAT); j++) pipeBusy = pipeBusy | pipe[j].valid;
   end

   assign tail     = pipe[MEM_LAT-1];
   assign tailOver = (tail.k >> BUF_AW) != '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = (emptyMap || lastElem) ? DRAIN : ISSUE;
         ISSUE:   if (lastElem) nextState = DRAIN;
         DRAIN:   if (!pipeBusy) nextState = FIN;
         FIN:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      memRdEnNext = issuing && !border;
      memAddrNext = memRdEnNext ? elemAddr : ADDR_W'(0);
      busyNext    = (nextState != IDLE);
      doneNext    = (nextState == FIN);
   end

   // Border zeros ride the same pipeline as reads so buffer order is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_rd_en <= 1'b0;
         bus.mem_addr  <= '0;
         bus.buf_we    <= 1'b0;
         bus.buf_addr  <= '0;
         bufInterior   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         cfgN          <= '0;
         cfgC          <= '0;
         cfgStride     <= '0;
         cfgPad        <= 1'b0;
         cfgS          <= '0;
         chIdx         <= '0;
         rowIdx        <= '0;
         colIdx        <= '0;
         kIdx          <= '0;
         chBase        <= '0;
         rowAddr       <= '0;
         for (int j = 0; j < int'(MEM_LAT); j++) pipe[j] <= '0;
      end else begin
         bus.mem_rd_en <= memRdEnNext;
         bus.mem_addr  <= memAddrNext;
         busy          <= busyNext;
         done          <= doneNext;

         if (inIdle && start) begin
            cfgN      <= img_size;
            cfgC      <= num_ch;
            cfgStride <= ch_stride;
            cfgPad    <= pad_en;
            cfgS      <= effS;
            overflow  <= 1'b0;
         end

         if (issuing) begin
            kIdx   <= curK + K_W'(1);
            colIdx <= lastCol ? '0 : curCol + S_W'(1);
            if (!lastCol) begin
               rowIdx  <= curRow;
               chIdx   <= curCh;
               chBase  <= curChBase;
               rowAddr <= curRowAddr;
            end else if (!lastRow) begin
               rowIdx  <= curRow + S_W'(1);
               chIdx   <= curCh;
               chBase  <= curChBase;
               rowAddr <= curRowAddr + ADDR_W'(effN);
            end else begin
               rowIdx  <= '0;
               chIdx   <= curCh + CH_W'(1);
               chBase  <= curChBase + effStride;
               rowAddr <= curChBase + effStride - padOff;
            end
         end

         pipe[0] <= '{valid: issuing, interior: memRdEnNext, k: curK};
         for (int j = 1; j < int'(MEM_LAT); j++) pipe[j] <= pipe[j-1];

         bus.buf_we   <= tail.valid && !tailOver;
         bus.buf_addr <= (tail.valid && !tailOver) ? BUF_AW'(tail.k) : BUF_AW'(0);
         bufInterior  <= tail.valid && tail.interior && !tailOver;
         if (tail.valid && tailOver) overflow <= 1'b1;
      end
   end

   assign bus.buf_data = bufInterior ? bus.mem_rd_data : DATA_W'(0);
endmodule

// File: tb/tb_img_tile_loader.sv
// Randomized scoreboard bench for img_tile_loader: a behavioural model queues
// expected reads, writes and done pulses; a negedge monitor pops and compares.
module tb_img_tile_loader;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned SIZE_W  = 6;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned BUF_AW  = 8;
   localparam int unsigned MEM_LAT = 2;

   typedef struct { int cyc; int a; int d; } evT;

   logic              clk = 1'b0;
   logic              reset, start, pad_en;
   logic [ADDR_W-1:0] base_addr, ch_stride;
   logic [SIZE_W-1:0] img_size;
   logic [CH_W-1:0]   num_ch;
   logic              busy, done, overflow;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int busyFrom = 1;
   int busyTo = 0;
   bit monOn = 1'b0;
   evT rdQ[$], wrQ[$], doneQ[$];

   logic [DATA_W-1:0] memArr [65536];
   logic [ADDR_W-1:0] rdAddrPipe [MEM_LAT];
   bit                rdVldPipe [MEM_LAT];

   img_tile_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_AW(BUF_AW)) bus ();

   img_tile_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
      .CH_W(CH_W), .BUF_AW(BUF_AW), .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .img_size(img_size), .num_ch(num_ch), .ch_stride(ch_stride),
      .pad_en(pad_en), .bus(bus), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory with MEM_LAT read latency; junk when no read is returning.
   always @(posedge clk) begin
      rdAddrPipe[0] <= bus.mem_addr;
      rdVldPipe[0]  <= bus.mem_rd_en;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
         rdAddrPipe[i] <= rdAddrPipe[i-1];
         rdVldPipe[i]  <= rdVldPipe[i-1];
      end
   end
   assign bus.mem_rd_data = rdVldPipe[MEM_LAT-1] ? memArr[rdAddrPipe[MEM_LAT-1]] : 16'hDEAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expected behaviour straight from the map geometry: element k issues at t+1+k.
   task automatic model(input int t, input int n, input int c, input int pad,
                        input int base, input int stride, output int doneCyc);
      int s, e, k, addr, data;
      bit ovf;
      s = n + 2 * pad;
      e = (n == 0 || c == 0) ? 0 : c * s * s;
      k = 0;
      ovf = 1'b0;
      if (e > 0) begin
         for (int ch = 0; ch < c; ch++)
            for (int r = 0; r < s; r++)
               for (int col = 0; col < s; col++) begin
                  if (pad != 0 && (r == 0 || r == s - 1 || col == 0 || col == s - 1)) data = 0;
                  else begin
                     addr = (base + ch * stride + (r - pad) * n + (col - pad)) & 32'hFFFF;
                     rdQ.push_back('{t + 1 + k, addr, 0});
                     data = int'(memArr[addr]);
                  end
                  if (k < (1 << BUF_AW)) wrQ.push_back('{t + 1 + k + int'(MEM_LAT), k, data});
                  else ovf = 1'b1;
                  k++;
               end
      end
      doneCyc = (e == 0) ? t + 2 : t + e + int'(MEM_LAT) + 1;
      doneQ.push_back('{doneCyc, int'(ovf), 0});
      busyFrom = t + 1;
      busyTo   = doneCyc;
   endtask

   task automatic scramble();
      base_addr = ADDR_W'($urandom);
      ch_stride = ADDR_W'($urandom);
      img_size  = SIZE_W'($urandom);
      num_ch    = CH_W'($urandom);
      pad_en    = 1'($urandom);
   endtask

   task automatic checkIdle(input string tag);
      check({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 0);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
      check({tag, "_buf_we"}, 32'(bus.buf_we), 0);
      check({tag, "_buf_addr"}, 32'(bus.buf_addr), 0);
      check({tag, "_buf_data"}, 32'(bus.buf_data), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
   endtask

   // extra: cycle offset of an ignored second start; resetAt: offset of a mid-run reset.
   task automatic runJob(input int n, input int c, input int pad, input int base,
                         input int stride, input int extra, input int resetAt);
      int t, doneCyc;
      @(posedge clk); #1;
      img_size  = SIZE_W'(n);
      num_ch    = CH_W'(c);
      pad_en    = (pad != 0);
      base_addr = ADDR_W'(base);
      ch_stride = ADDR_W'(stride);
      start     = 1'b1;
      t = cyc;
      model(t, n, c, pad, base, stride, doneCyc);
      @(posedge clk); #1;
      while (cyc <= doneCyc) begin
         if (resetAt > 0 && cyc == t + resetAt) begin
            reset = 1'b1;
            start = 1'b0;
            @(posedge clk); #1;
            rdQ.delete();
            wrQ.delete();
            doneQ.delete();
            busyFrom = 1;
            busyTo   = 0;
            checkIdle("midreset");
            reset = 1'b0;
            return;
         end
         start = (extra > 0) && (cyc == t + extra);
         scramble();
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   always @(negedge clk) begin
      int expC;
      if (monOn) begin
         while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
            check("rd_cycle", cyc, rdQ[0].cyc);
            void'(rdQ.pop_front());
         end
         while (wrQ.size() > 0 && wrQ[0].cyc < cyc) begin
            check("wr_cycle", cyc, wrQ[0].cyc);
            void'(wrQ.pop_front());
         end
         while (doneQ.size() > 0 && doneQ[0].cyc < cyc) begin
            check("done_cycle", cyc, doneQ[0].cyc);
            void'(doneQ.pop_front());
         end
         if (bus.mem_rd_en) begin
            expC = (rdQ.size() > 0) ? rdQ[0].cyc : -1;
            check("rd_cycle", cyc, expC);
            if (expC == cyc) begin
               check("rd_addr", 32'(bus.mem_addr), rdQ[0].a);
               void'(rdQ.pop_front());
            end
         end
         if (bus.buf_we) begin
            expC = (wrQ.size() > 0) ? wrQ[0].cyc : -1;
            check("wr_cycle", cyc, expC);
            if (expC == cyc) begin
               check("wr_addr", 32'(bus.buf_addr), wrQ[0].a);
               check("wr_data", 32'(bus.buf_data), wrQ[0].d);
               void'(wrQ.pop_front());
            end
         end
         if (done) begin
            expC = (doneQ.size() > 0) ? doneQ[0].cyc : -1;
            check("done_cycle", cyc, expC);
            if (expC == cyc) begin
               check("overflow", 32'(overflow), doneQ[0].a);
               void'(doneQ.pop_front());
            end
         end
         check("busy", 32'(busy), 32'(cyc >= busyFrom && cyc <= busyTo));
      end
   end

   initial begin
      for (int i = 0; i < 65536; i++) memArr[i] = DATA_W'($urandom);
      reset = 1'b1;
      start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      reset = 1'b0;
      monOn = 1'b1;

      runJob(6, 1, 0, 100, 0, 0, 0);          // plain 6x6 copy
      runJob(6, 1, 0, 100, 0, 5, 0);          // second start while busy is ignored
      runJob(2, 1, 1, 0, 0, 0, 0);            // padded 2x2 -> 4x4
      runJob(3, 3, 0, 200, 64, 0, 0);         // three channels, stride 64
      runJob(6, 1, 0, 100, 0, 0, 10);         // reset mid-transfer
      runJob(6, 1, 0, 100, 0, 0, 0);          // clean run after reset
      runJob(0, 2, 0, 5, 7, 0, 0);            // N=0
      runJob(4, 0, 1, 5, 7, 1, 0);            // C=0
      runJob(16, 1, 0, 300, 0, 0, 0);         // exactly fills the buffer
      runJob(17, 1, 0, 300, 0, 0, 0);         // overflows the buffer
      runJob(3, 1, 0, 1, 0, 0, 0);            // overflow cleared again
      runJob(3, 1, 0, 32'hFFFE, 0, 0, 0);     // address wrap
      runJob(2, 2, 1, 32'hFFF0, 32'hFFF8, 0, 0);

      for (int j = 0; j < 25; j++) begin
         int extra;
         extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         runJob(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), extra, 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      #1;
      check("rd_left", rdQ.size(), 0);
      check("wr_left", wrQ.size(), 0);
      check("done_left", doneQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
